roi_crop_stream: RTL and testbench
==================================

Name: roi_crop_stream

Overview:
Multi-pixel-per-beat successor to the single-pixel crop stage. Crops an IN_ROWS x IN_COLS AXI4-Stream frame to an OUT_ROWS x OUT_COLS region of interest.
- Row/column tracking is internal, driven by the input tuser/tlast framing; there is no external counter input.
- Crop coordinates are latched per frame.
- Cropped beats are buffered in an internal FIFO and emitted with tuser/tlast framing.
- Per-frame max (and optional min) statistics are reported for the downstream normaliser.

Parameters:
- PIXEL_BIT_WIDTH, 10, bits per pixel.
- PPB, 4, pixels per beat; IN_COLS and OUT_COLS must be multiples of PPB.
- IN_ROWS, 64, input frame rows.
- IN_COLS, 64, input frame columns.
- OUT_ROWS, 32, cropped rows.
- OUT_COLS, 32, cropped columns.
- FIFO_DEPTH, 16, output FIFO depth in beats (power of 2, >=2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ap_start  in  1  arm for one frame; accepted only while ap_ready=1.
- ap_ready  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse after the final ROI beat is written to the FIFO.
- ap_idle  out  1  high in IDLE with FIFO empty.
- crop_x0  in  $clog2(IN_COLS)  ROI left column, sampled at ap_start.
- crop_y0  in  $clog2(IN_ROWS)  ROI top row, sampled at ap_start.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat ready.
- s_axis_tdata  in  PPB*PIXEL_BIT_WIDTH  input pixels; lane 0 (LSBs) is the lowest column.
- s_axis_tuser  in  1  start of frame.
- s_axis_tlast  in  1  end of line.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  output beat ready.
- m_axis_tdata  out  PPB*PIXEL_BIT_WIDTH  cropped pixels.
- m_axis_tuser  out  1  first beat of the cropped frame.
- m_axis_tlast  out  1  last beat of each cropped row.
- max_value  out  PIXEL_BIT_WIDTH  maximum pixel value in the ROI.
- err_framing  out  1  sticky framing error.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy in beats.

Behaviour:
- Reset: FSM=IDLE, FIFO emptied, all outputs 0 except ap_ready=1 and ap_idle=1. Reset mid-frame discards all in-flight data.
- ap_start && ap_ready:
  - Latch x0 = crop_x0 rounded down to a multiple of PPB.
  - If x0+OUT_COLS > IN_COLS, x0 = IN_COLS-OUT_COLS. Apply the same clamp to y0 against IN_ROWS-OUT_ROWS.
  - Clear max_value and err_framing.
  - Next state WAIT_SOF.
- WAIT_SOF: tready=1; beats dropped until tvalid&&tuser. That beat is (row 0, col 0): it is classified and processed, then state -> CROP.
- CROP, per accepted beat:
  - col += PPB. At col==IN_COLS-PPB, col wraps to 0 and row increments.
  - A beat is an ROI beat when y0 <= row < y0+OUT_ROWS and x0 <= col < x0+OUT_COLS.
  - tready = ROI beat ? !fifo_full : 1. Non-ROI beats are never stalled.
  - tready depends on state and counters only, never on tvalid.
- FIFO entry = {tuser, tlast, tdata}.
  - tuser=1 on ROI beat (y0, x0).
  - tlast=1 when col==x0+OUT_COLS-PPB.
- FIFO is first-word-fall-through: m_axis_tvalid rises 1 cycle after the beat is accepted. Simultaneous push and pop on a full FIFO is allowed; level is unchanged.
- max_value updates in the same cycle as each ROI push, using the max across all PPB lanes. It holds from ap_done until the next ap_start.
- Final ROI beat (row y0+OUT_ROWS-1, col x0+OUT_COLS-PPB) accepted: ap_done pulses the next cycle, then state -> FLUSH.
- FLUSH: tready=1. Remaining beats are consumed until the last beat of the frame (row IN_ROWS-1, col IN_COLS-PPB), then state -> IDLE.
- Framing errors set err_framing; internal counters remain authoritative. Error cases:
  - tlast present when col != IN_COLS-PPB, or absent when col == IN_COLS-PPB.
  - tuser on any beat other than (0,0) in CROP or FLUSH.
- IDLE: s_axis_tready=0.
- Counter widths: $clog2(IN_COLS+1) and $clog2(IN_ROWS+1). Compare as unsigned with no overflow.

Optional Feature:
CROP_MIN_STAT_EN:
- Defined: adds output min_value[PIXEL_BIT_WIDTH-1:0]. It is set to all-ones at ap_start, takes the min across ROI lanes on each push, and holds after ap_done.
- Undefined: the port is absent, and no min logic is generated.

Test Plan:
- IN 8x8, PPB=2, OUT 4x4, crop (2,3), pixel=row*8+col, m_axis_tready=1 -> 8 output beats; first tdata lanes {27,26} with tuser=1; tlast on beats 2,4,6,8; ap_done once; max_value=53; min_value=26 with CROP_MIN_STAT_EN.
- Same frame with m_axis_tready=0 and FIFO_DEPTH=4 -> fifo_level reaches 4; s_axis_tready drops only on ROI beats; enabling tready yields 8 beats in order with no loss.
- crop_x0=7, crop_y0=7 -> clamped to (4,4); first output lanes {37,36}; max_value=63.
- Early tlast at col 4 of row 1 -> err_framing=1; crop output still 8 beats, counted internally; err_framing cleared at the next ap_start.
- Two beats before the tuser beat, then reset asserted mid-CROP -> pre-SOF beats are dropped; after reset, FIFO empty, ap_ready=1, m_axis_tvalid=0; a following clean frame passes the first test.

Source files
------------

// File: rtl/roi_crop_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : roi_crop_stream_if
//  Purpose  : AXI4-Stream beat bundle (valid/ready handshake, data, tuser
//             start-of-frame, tlast end-of-line) shared by the crop stage's
//             input and output sides.
//  Ports    : tvalid, tready, tdata[DATA_W-1:0], tuser, tlast
//             master modport drives the beat, slave modport drives tready.
//  Revision : 1.0  initial release
// ============================================================================
interface roi_crop_stream_if #(
    parameter int DATA_W = 40
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tuser;
    logic              tlast;

    modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/roi_crop_stream.sv
`default_nettype none
// ============================================================================
//  Module   : roi_crop_stream
//  Purpose  : Crops an IN_ROWS x IN_COLS multi-pixel-per-beat AXI4-Stream
//             frame to an OUT_ROWS x OUT_COLS region of interest. Position is
//             tracked internally from tuser/tlast framing, cropped beats go
//             through a first-word-fall-through FIFO, and per-frame max
//             (optionally min) pixel statistics are reported.
//  Ports    : clk, reset (sync, active-high)
//             ap_start/ap_ready/ap_done/ap_idle  frame control
//             crop_x0, crop_y0                   ROI origin, sampled at start
//             s_axis (slave), m_axis (master)    input / cropped output stream
//             max_value, err_framing, fifo_level status
//             min_value                          only with CROP_MIN_STAT_EN
//  Options  : `define CROP_MIN_STAT_EN adds the min_value statistic.
//  Revision : 1.0  initial release
// ============================================================================
module roi_crop_stream #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int PPB             = 4,
    parameter int IN_ROWS         = 64,
    parameter int IN_COLS         = 64,
    parameter int OUT_ROWS        = 32,
    parameter int OUT_COLS        = 32,
    parameter int FIFO_DEPTH      = 16
) (
    input  wire logic                               clk,
    input  wire logic                               reset,
    input  wire logic                               ap_start,
    output logic                                    ap_ready,
    output logic                                    ap_done,
    output logic                                    ap_idle,
    input  wire logic [$clog2(IN_COLS)-1:0]         crop_x0,
    input  wire logic [$clog2(IN_ROWS)-1:0]         crop_y0,
    roi_crop_stream_if.slave                        s_axis,
    roi_crop_stream_if.master                       m_axis,
    output logic [PIXEL_BIT_WIDTH-1:0]              max_value,
`ifdef CROP_MIN_STAT_EN
    output logic [PIXEL_BIT_WIDTH-1:0]              min_value,
`endif
    output logic                                    err_framing,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]         fifo_level
);
    localparam int c_dw = PPB * PIXEL_BIT_WIDTH;
    localparam int c_cw = $clog2(IN_COLS + 1);
    localparam int c_rw = $clog2(IN_ROWS + 1);
    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_lw = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_cw-1:0] c_x0_max   = c_cw'(IN_COLS - OUT_COLS);
    localparam logic [c_rw-1:0] c_y0_max   = c_rw'(IN_ROWS - OUT_ROWS);
    localparam logic [c_cw-1:0] c_col_last = c_cw'(IN_COLS - PPB);
    localparam logic [c_rw-1:0] c_row_last = c_rw'(IN_ROWS - 1);
    localparam logic [c_cw-1:0] c_ppb      = c_cw'(PPB);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_SOF = 2'd1,
        S_CROP     = 2'd2,
        S_FLUSH    = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [c_rw-1:0]             row_q, row_d, y0_q, y0_d;
    logic [c_cw-1:0]             col_q, col_d, x0_q, x0_d;
    logic [PIXEL_BIT_WIDTH-1:0]  max_q, max_d;
    logic                        err_q, err_d, done_q, done_d;
    logic [c_aw-1:0]             wr_q, wr_d, rd_q, rd_d;
    logic [c_lw-1:0]             cnt_q, cnt_d;
    logic [c_dw+1:0]             mem [FIFO_DEPTH];

    logic [c_cw:0]               w_x_end;
    logic [c_rw:0]               w_y_end;
    logic [c_cw-1:0]             w_x0_round;
    logic [c_rw-1:0]             w_y0_in;
    logic                        w_roi_hit, w_roi_first, w_roi_eol, w_roi_final;
    logic                        w_col_last, w_frame_last, w_fifo_full;
    logic                        w_in_ready, w_beat, w_push, w_pop;
    logic [PIXEL_BIT_WIDTH-1:0]  w_lane, w_lane_max;

    // Exclusive ROI bounds, one bit wider so x0+OUT_COLS never wraps.
    assign w_x_end      = {1'b0, x0_q} + (c_cw+1)'(OUT_COLS);
    assign w_y_end      = {1'b0, y0_q} + (c_rw+1)'(OUT_ROWS);
    assign w_roi_hit    = (row_q >= y0_q) && ({1'b0, row_q} < w_y_end) &&
                          (col_q >= x0_q) && ({1'b0, col_q} < w_x_end);
    assign w_roi_first  = w_roi_hit && (row_q == y0_q) && (col_q == x0_q);
    assign w_roi_eol    = ({1'b0, col_q} == (w_x_end - (c_cw+1)'(PPB)));
    assign w_roi_final  = w_roi_hit && w_roi_eol && ({1'b0, row_q} == (w_y_end - (c_rw+1)'(1)));
    assign w_col_last   = (col_q == c_col_last);
    assign w_frame_last = w_col_last && (row_q == c_row_last);
    assign w_fifo_full  = (cnt_q == c_lw'(FIFO_DEPTH));

    // Counters sit at (0,0) while waiting for SOF, so the ROI test also covers
    // the SOF beat; an ROI at the origin must respect FIFO space there too.
    assign w_in_ready = (state_q == S_IDLE)  ? 1'b0 :
                        (state_q == S_FLUSH) ? 1'b1 :
                        (w_roi_hit ? !w_fifo_full : 1'b1);
    assign w_beat = s_axis.tvalid && w_in_ready && ((state_q != S_WAIT_SOF) || s_axis.tuser);
    assign w_push = w_beat && w_roi_hit && (state_q != S_FLUSH);
    assign w_pop  = m_axis.tvalid && m_axis.tready;

    assign w_x0_round = (c_cw'(crop_x0) / c_ppb) * c_ppb;
    assign w_y0_in    = c_rw'(crop_y0);

    always_comb begin
        w_lane     = '0;
        w_lane_max = '0;
        for (int i = 0; i < PPB; i++) begin
            w_lane = s_axis.tdata[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
            if (w_lane > w_lane_max) w_lane_max = w_lane;
        end
    end

`ifdef CROP_MIN_STAT_EN
    logic [PIXEL_BIT_WIDTH-1:0] min_q, min_d, w_lane_lo, w_lane_min;

    always_comb begin
        w_lane_lo  = '0;
        w_lane_min = '1;
        for (int i = 0; i < PPB; i++) begin
            w_lane_lo = s_axis.tdata[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
            if (w_lane_lo < w_lane_min) w_lane_min = w_lane_lo;
        end
    end

    always_comb begin
        min_d = min_q;
        if (state_q == S_IDLE && ap_start) min_d = '1;
        else if (w_push && w_lane_min < min_q) min_d = w_lane_min;
    end

    always_ff @(posedge clk) begin
        if (reset) min_q <= '0;
        else       min_q <= min_d;
    end

    assign min_value = min_q;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        max_d   = max_q;
        err_d   = err_q;
        done_d  = 1'b0;

        if (state_q == S_IDLE && ap_start) begin
            x0_d    = (w_x0_round > c_x0_max) ? c_x0_max : w_x0_round;
            y0_d    = (w_y0_in > c_y0_max) ? c_y0_max : w_y0_in;
            row_d   = '0;
            col_d   = '0;
            max_d   = '0;
            err_d   = 1'b0;
            state_d = S_WAIT_SOF;
        end

        if (w_beat) begin
            if (s_axis.tlast != w_col_last) err_d = 1'b1;
            if (state_q != S_WAIT_SOF && s_axis.tuser && (row_q != '0 || col_q != '0))
                err_d = 1'b1;

            if (w_col_last) begin
                col_d = '0;
                row_d = (row_q == c_row_last) ? '0 : row_q + c_rw'(1);
            end else begin
                col_d = col_q + c_ppb;
            end

            if (w_push && w_lane_max > max_q) max_d = w_lane_max;

            if (state_q == S_FLUSH) begin
                if (w_frame_last) state_d = S_IDLE;
            end else if (w_roi_final) begin
                done_d = 1'b1;
                // When the ROI ends on the frame's last beat there is nothing left to flush.
                state_d = w_frame_last ? S_IDLE : S_FLUSH;
            end else if (state_q == S_WAIT_SOF) begin
                state_d = S_CROP;
            end
        end
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (w_push) wr_d = wr_q + c_aw'(1);
        if (w_pop)  rd_d = rd_q + c_aw'(1);
        if (w_push && !w_pop)      cnt_d = cnt_q + c_lw'(1);
        else if (!w_push && w_pop) cnt_d = cnt_q - c_lw'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            max_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            max_q   <= max_d;
            err_q   <= err_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage needs no reset: the read side is gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) mem[wr_q] <= {w_roi_first, w_roi_eol, s_axis.tdata};
    end

    assign s_axis.tready = w_in_ready;
    assign m_axis.tvalid = (cnt_q != '0);
    assign m_axis.tdata  = m_axis.tvalid ? mem[rd_q][c_dw-1:0] : '0;
    assign m_axis.tlast  = m_axis.tvalid && mem[rd_q][c_dw];
    assign m_axis.tuser  = m_axis.tvalid && mem[rd_q][c_dw+1];

    assign ap_ready    = (state_q == S_IDLE);
    assign ap_idle     = ap_ready && (cnt_q == '0);
    assign ap_done     = done_q;
    assign max_value   = max_q;
    assign err_framing = err_q;
    assign fifo_level  = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_roi_crop_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_roi_crop_stream
//  Purpose  : Self-checking bench for roi_crop_stream on an 8x8 frame, PPB=2,
//             4x4 ROI, 4-beat FIFO. A queue model of the expected cropped
//             beats is compared against every output transfer; literal
//             expectations pin first beat, tlast pattern and statistics.
//  Revision : 1.0  initial release
// ============================================================================
module tb_roi_crop_stream;
    localparam int PW = 10, PPB = 2, IN_R = 8, IN_C = 8, OUT_R = 4, OUT_C = 4, FD = 4;
    localparam int DW = PW * PPB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ap_start = 1'b0;
    logic ap_ready, ap_done, ap_idle;
    logic [2:0] crop_x0 = '0;
    logic [2:0] crop_y0 = '0;
    logic [PW-1:0] max_value;
    logic err_framing;
    logic [2:0] fifo_level;
`ifdef CROP_MIN_STAT_EN
    logic [PW-1:0] min_value;
`endif

    roi_crop_stream_if #(.DATA_W(DW)) s_if ();
    roi_crop_stream_if #(.DATA_W(DW)) m_if ();

    roi_crop_stream #(
        .PIXEL_BIT_WIDTH(PW), .PPB(PPB), .IN_ROWS(IN_R), .IN_COLS(IN_C),
        .OUT_ROWS(OUT_R), .OUT_COLS(OUT_C), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_idle(ap_idle), .crop_x0(crop_x0), .crop_y0(crop_y0),
        .s_axis(s_if), .m_axis(m_if), .max_value(max_value),
`ifdef CROP_MIN_STAT_EN
        .min_value(min_value),
`endif
        .err_framing(err_framing), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int out_cnt, done_cnt;
    logic [7:0] last_mask;
    logic [DW-1:0] first_data;
    logic first_user;
    logic [DW+1:0] exp_q[$];
    int ex_x0, ex_y0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic logic [DW-1:0] beat_data(input int r, input int c);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < PPB; k++) d[k*PW +: PW] = PW'(r * IN_C + c + k);
        return d;
    endfunction

    function automatic logic in_roi(input int r, input int c);
        return (r >= ex_y0) && (r < ex_y0 + OUT_R) && (c >= ex_x0) && (c < ex_x0 + OUT_C);
    endfunction

    // Expected cropped stream derived directly from the crop rules.
    task automatic load_model(input int cx, input int cy);
        logic u, l;
        ex_x0 = (cx / PPB) * PPB;
        if (ex_x0 + OUT_C > IN_C) ex_x0 = IN_C - OUT_C;
        ex_y0 = cy;
        if (ex_y0 + OUT_R > IN_R) ex_y0 = IN_R - OUT_R;
        exp_q.delete();
        for (int r = ex_y0; r < ex_y0 + OUT_R; r++)
            for (int c = ex_x0; c < ex_x0 + OUT_C; c += PPB) begin
                u = (r == ex_y0) && (c == ex_x0);
                l = (c == ex_x0 + OUT_C - PPB);
                exp_q.push_back({u, l, beat_data(r, c)});
            end
    endtask

    // Output scoreboard: every transfer is compared against the model queue.
    always begin
        @(negedge clk);
        #2;
        if (ap_done) done_cnt++;
        if (m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
                chk("out_unexpected_beat", {m_if.tuser, m_if.tlast, m_if.tdata}, 64'hFFFF_FFFF);
            end else begin
                chk("out_beat", {m_if.tuser, m_if.tlast, m_if.tdata}, exp_q.pop_front());
            end
            if (out_cnt == 0) begin
                first_data = m_if.tdata;
                first_user = m_if.tuser;
            end
            if (out_cnt < 8) last_mask[out_cnt] = m_if.tlast;
            out_cnt++;
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l,
                             input logic roi, input logic chk_stall);
        int guard;
        guard = 0;
        @(negedge clk);
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        #1;
        while (!s_if.tready && guard < 500) begin
            if (chk_stall) chk("tready_low_only_on_roi", roi, 1);
            guard++;
            @(negedge clk);
            #1;
        end
        if (guard >= 500) chk("input_accept_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic run_frame(input int cx, input int cy, input int early_row,
                             input int pre, input int stop_at);
        int n;
        logic lst;
        n = 0;
        load_model(cx, cy);
        out_cnt = 0; done_cnt = 0; last_mask = '0; first_data = '0; first_user = 1'b0;
        @(negedge clk);
        crop_x0 = 3'(cx);
        crop_y0 = 3'(cy);
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        #1;
        chk("err_clear_at_start", err_framing, 0);
        chk("max_clear_at_start", max_value, 0);
        for (int i = 0; i < pre; i++) send_beat(DW'(i + 900), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < IN_R; r++)
            for (int c = 0; c < IN_C; c += PPB)
                if (stop_at < 0 || n < stop_at) begin
                    lst = (c == IN_C - PPB) || (r == early_row && c == 4);
                    send_beat(beat_data(r, c), (r == 0 && c == 0), lst, in_roi(r, c), 1'b1);
                    n++;
                end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic check_frame(input logic [DW-1:0] first_lit, input int max_lit, input int min_lit);
        int guard;
        guard = 0;
        @(negedge clk);
        #3;
        while ((exp_q.size() != 0 || m_if.tvalid) && guard < 300) begin
            @(negedge clk);
            #3;
            guard++;
        end
        chk("drain_remaining", exp_q.size(), 0);
        chk("out_beat_count", out_cnt, 8);
        chk("tlast_pattern", last_mask, 8'hAA);
        chk("first_tdata", first_data, first_lit);
        chk("first_tuser", first_user, 1);
        chk("ap_done_pulses", done_cnt, 1);
        chk("max_value", max_value, max_lit);
`ifdef CROP_MIN_STAT_EN
        chk("min_value", min_value, min_lit);
`else
        if (min_lit < 0) chk("min_lit_sane", 0, 1);
`endif
        chk("ap_idle_after_frame", ap_idle, 1);
        chk("s_tready_in_idle", s_if.tready, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g, peak;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
        m_if.tready = 1'b1;
        out_cnt = 0; done_cnt = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ap_ready", ap_ready, 1);
        chk("rst_ap_idle", ap_idle, 1);
        chk("rst_ap_done", ap_done, 0);
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_s_tready", s_if.tready, 0);
        chk("rst_err", err_framing, 0);
        chk("rst_max", max_value, 0);
        reset = 1'b0;

        // Basic crop (2,3), free-flowing output
        run_frame(2, 3, -1, 0, -1);
        check_frame({10'd27, 10'd26}, 53, 26);

        // Output stalled: FIFO fills, input stalls only on ROI beats
        m_if.tready = 1'b0;
        fork
            run_frame(2, 3, -1, 0, -1);
            begin
                g = 0; peak = 0;
                while (g < 400 && peak < FD) begin
                    @(negedge clk);
                    #1;
                    if (int'(fifo_level) > peak) peak = int'(fifo_level);
                    g++;
                end
                chk("fifo_level_peak", peak, FD);
                repeat (4) @(negedge clk);
                m_if.tready = 1'b1;
            end
        join
        check_frame({10'd27, 10'd26}, 53, 26);

        // Clamped origin (7,7) -> (4,4); ROI ends on the frame's last beat
        run_frame(7, 7, -1, 0, -1);
        check_frame({10'd37, 10'd36}, 63, 36);

        // Early tlast on row 1 col 4
        run_frame(2, 3, 1, 0, -1);
        check_frame({10'd27, 10'd26}, 53, 26);
        chk("err_framing_set", err_framing, 1);

        // Pre-SOF junk beats, then reset in the middle of the crop
        run_frame(2, 3, -1, 2, 20);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        exp_q.delete();
        reset = 1'b0;
        chk("midrst_fifo_level", fifo_level, 0);
        chk("midrst_ap_ready", ap_ready, 1);
        chk("midrst_m_tvalid", m_if.tvalid, 0);
        chk("midrst_max", max_value, 0);

        // Clean frame after the reset
        run_frame(2, 3, -1, 0, -1);
        check_frame({10'd27, 10'd26}, 53, 26);
        chk("err_clean_frame", err_framing, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
